stream_mux_rr: RTL and testbench

Parametrised N-to-1 streaming multiplexer with a valid/ready handshake on every input channel and on the output. It selects one channel per cycle, either by round-robin arbitration or by a directly driven select, and holds the chosen word in a single registered output stage. It is the successor to the team's fixed 4:1 combinational mux and is used wherever several producers share one downstream consumer.

---
 rtl/stream_mux_rr.sv | 124 ++++++++++++
 tb/tb_stream_mux_rr.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with a single
// registered output stage. A channel is chosen each cycle either by a
// round-robin search starting at PTR (MODE=0) or by a direct select (MODE=1).
//
// Handshake: a word moves across any valid/ready pair on a rising edge where
// both valid and ready are 1. Ready may depend on valid; valid must never
// depend on ready. X_READY is combinational and one-hot or zero. The output
// slot accepts a new word whenever it is empty or being drained this cycle.
module stream_mux_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N*W-1:0]  X_DATA,
  input  logic [N-1:0]    X_VALID,
  output logic [N-1:0]    X_READY,
  input  logic            MODE,
  input  logic [SW-1:0]   SEL,
  output logic [W-1:0]    F_DATA,
  output logic [SW-1:0]   F_CH,
  output logic            F_VALID,
  input  logic            F_READY
);

  logic [W-1:0]  f_data_q, f_data_d;
  logic [SW-1:0] f_ch_q, f_ch_d;
  logic          f_valid_q, f_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          slot_free;
  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          dir_found;
  logic          grant;
  logic [SW-1:0] gnt_idx;
  logic [W-1:0]  gnt_data;

  // Output slot can take a word when empty or when its word leaves this edge.
  assign slot_free = !f_valid_q || F_READY;

  // Round-robin: pick the valid channel with the smallest distance from PTR,
  // measured forward modulo N, so PTR itself has top priority.
  always_comb begin
    int best_d;
    int d;
    rr_found = 1'b0;
    rr_idx   = '0;
    best_d   = N;
    d        = 0;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(ptr_q)) d = i - int'(ptr_q);
      else                  d = i + N - int'(ptr_q);
      if (X_VALID[i] && (d < best_d)) begin
        best_d   = d;
        rr_found = 1'b1;
        rr_idx   = SW'(i);
      end
    end
  end

  // Direct select: only SEL may win; an out-of-range SEL matches no channel.
  always_comb begin
    dir_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if ((SEL == SW'(i)) && X_VALID[i]) dir_found = 1'b1;
    end
  end

  // Grant decision; held off entirely while reset is asserted.
  always_comb begin
    gnt_idx = MODE ? SEL : rr_idx;
    grant   = RST_N && slot_free && (MODE ? dir_found : rr_found);
  end

  // One-hot ready towards the granted channel, and its data word.
  always_comb begin
    X_READY  = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        X_READY[i] = grant;
        gnt_data   = X_DATA[i*W +: W];
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    f_data_d  = f_data_q;
    f_ch_d    = f_ch_q;
    f_valid_d = f_valid_q;
    ptr_d     = ptr_q;
    if (grant) begin
      f_data_d  = gnt_data;
      f_ch_d    = gnt_idx;
      f_valid_d = 1'b1;
      if (!MODE) ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
    end else if (slot_free) begin
      f_valid_d = 1'b0;
    end
  end

  // State registers; asynchronous reset discards any held word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      f_data_q  <= '0;
      f_ch_q    <= '0;
      f_valid_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      f_data_q  <= f_data_d;
      f_ch_q    <= f_ch_d;
      f_valid_q <= f_valid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign F_DATA  = f_data_q;
  assign F_CH    = f_ch_q;
  assign F_VALID = f_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed, table-driven bench for stream_mux_rr with a
// 4-channel instance plus a 3-channel instance for the non-power-of-two case.
module tb_stream_mux_rr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- N=4 instance ----------------
  logic [31:0] x_data;
  logic [3:0]  x_valid;
  logic [3:0]  x_ready;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  f_data;
  logic [1:0]  f_ch;
  logic        f_valid;
  logic        f_ready;

  stream_mux_rr #(.N(4), .W(8)) dut (
    .CLK(clk), .RST_N(rst_n), .X_DATA(x_data), .X_VALID(x_valid),
    .X_READY(x_ready), .MODE(mode), .SEL(sel), .F_DATA(f_data),
    .F_CH(f_ch), .F_VALID(f_valid), .F_READY(f_ready)
  );

  // ---------------- N=3 instance ----------------
  logic [23:0] x3_data;
  logic [2:0]  x3_valid;
  logic [2:0]  x3_ready;
  logic        mode3;
  logic [1:0]  sel3;
  logic [7:0]  f3_data;
  logic [1:0]  f3_ch;
  logic        f3_valid;
  logic        f3_ready;

  stream_mux_rr #(.N(3), .W(8)) dut3 (
    .CLK(clk), .RST_N(rst_n), .X_DATA(x3_data), .X_VALID(x3_valid),
    .X_READY(x3_ready), .MODE(mode3), .SEL(sel3), .F_DATA(f3_data),
    .F_CH(f3_ch), .F_VALID(f3_valid), .F_READY(f3_ready)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] xv;
    logic       md;
    logic [1:0] sl;
    logic       frdy;
    logic [3:0] xr;    // expected X_READY before the edge
    logic       fv;    // expected outputs after the edge
    logic [7:0] fd;
    logic [1:0] ch;
    logic [1:0] ptr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] xv, logic md, logic [1:0] sl, logic frdy,
                              logic [3:0] xr, logic fv, logic [7:0] fd,
                              logic [1:0] ch, logic [1:0] ptr);
    vec_t v;
    v.xv = xv; v.md = md; v.sl = sl; v.frdy = frdy;
    v.xr = xr; v.fv = fv; v.fd = fd; v.ch = ch; v.ptr = ptr;
    return v;
  endfunction

  // Drive one cycle of inputs, check ready, clock, check registered state.
  task automatic apply(input vec_t v, input string tag);
    x_valid = v.xv;
    mode    = v.md;
    sel     = v.sl;
    f_ready = v.frdy;
    #1;
    chk({tag, " x_ready"}, 32'(x_ready), 32'(v.xr));
    @(posedge clk);
    #1;
    exp_q.push_back({22'd0, v.fv, v.fd, v.ch});
    chk({tag, " f_out"}, {22'd0, f_valid, f_data, f_ch}, exp_q.pop_front());
    chk({tag, " ptr"}, 32'(dut.ptr_q), 32'(v.ptr));
  endtask

  initial begin
    x_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    x_valid  = 4'b1111;
    mode     = 1'b0;
    sel      = 2'd0;
    f_ready  = 1'b1;
    x3_data  = {8'hB2, 8'hB1, 8'hB0};
    x3_valid = 3'b000;
    mode3    = 1'b0;
    sel3     = 2'd0;
    f3_ready = 1'b1;

    // Reset held with every channel valid: nothing granted, outputs cleared.
    #12;
    chk("rst x_ready", 32'(x_ready), 32'h0);
    chk("rst f_valid", 32'(f_valid), 32'h0);
    chk("rst f_data", 32'(f_data), 32'h0);
    chk("rst f_ch", 32'(f_ch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // The first edge after release already transferred channel 0.
    chk("first grant ch", 32'(f_ch), 32'h0);
    chk("first grant data", 32'(f_data), 32'hA0);
    // Return to an idle, PTR=0-equivalent starting point via a fresh reset.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;

    //             xv     md  sl  frdy  xr      fv  fd     ch  ptr
    // round-robin, all valid
    vecs.push_back(mk(4'b1111, 0, 0, 1, 4'b0001, 1, 8'hA0, 0, 1));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 4'b0010, 1, 8'hA1, 1, 2));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 4'b0100, 1, 8'hA2, 2, 3));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 4'b1000, 1, 8'hA3, 3, 0));
    vecs.push_back(mk(4'b1111, 0, 0, 1, 4'b0001, 1, 8'hA0, 0, 1));
    vecs.push_back(mk(4'b0010, 0, 0, 1, 4'b0010, 1, 8'hA1, 1, 2));
    // sparse with wrap: channels 1 and 3 from PTR=2
    vecs.push_back(mk(4'b1010, 0, 0, 1, 4'b1000, 1, 8'hA3, 3, 0));
    vecs.push_back(mk(4'b1010, 0, 0, 1, 4'b0010, 1, 8'hA1, 1, 2));
    vecs.push_back(mk(4'b1010, 0, 0, 1, 4'b1000, 1, 8'hA3, 3, 0));
    vecs.push_back(mk(4'b1010, 0, 0, 1, 4'b0010, 1, 8'hA1, 1, 2));
    // search wraps past N-1 to channel 0
    vecs.push_back(mk(4'b0001, 0, 0, 1, 4'b0001, 1, 8'hA0, 0, 1));
    // idle: valid drops, data/ch keep
    vecs.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 0, 8'hA0, 0, 1));
    // direct select 2, PTR must stay at 1
    vecs.push_back(mk(4'b1111, 1, 2, 1, 4'b0100, 1, 8'hA2, 2, 1));
    vecs.push_back(mk(4'b1111, 1, 2, 1, 4'b0100, 1, 8'hA2, 2, 1));
    // selected channel not valid: no grant even though others are valid
    vecs.push_back(mk(4'b1011, 1, 2, 1, 4'b0000, 0, 8'hA2, 2, 1));
    vecs.push_back(mk(4'b1000, 1, 0, 1, 4'b0000, 0, 8'hA2, 2, 1));
    // empty slot accepts even with F_READY=0; then it is full and holds
    vecs.push_back(mk(4'b1111, 0, 0, 0, 4'b0010, 1, 8'hA1, 1, 2));
    vecs.push_back(mk(4'b1111, 0, 0, 0, 4'b0000, 1, 8'hA1, 1, 2));

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: load 0x55 from channel 2, stall 5 cycles, then drain+fill.
    x_data[16 +: 8] = 8'h55;
    apply(mk(4'b0100, 0, 0, 1, 4'b0100, 1, 8'h55, 2, 3), "bp load");
    for (int k = 0; k < 5; k++)
      apply(mk(4'b1111, 0, 0, 0, 4'b0000, 1, 8'h55, 2, 3), $sformatf("bp hold%0d", k));
    x_data[16 +: 8] = 8'hA2;
    apply(mk(4'b1111, 0, 0, 1, 4'b1000, 1, 8'hA3, 3, 0), "bp release");
    apply(mk(4'b1111, 0, 0, 1, 4'b0001, 1, 8'hA0, 0, 1), "pre-reset");

    // Reset mid-stream while a word is held and PTR=1.
    x_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("midrst f_valid", 32'(f_valid), 32'h0);
    chk("midrst f_data", 32'(f_data), 32'h0);
    chk("midrst x_ready", 32'(x_ready), 32'h0);
    chk("midrst ptr", 32'(dut.ptr_q), 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk("postrst x_ready", 32'(x_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("postrst f_ch", 32'(f_ch), 32'h0);
    chk("postrst f_valid", 32'(f_valid), 32'h1);
    chk("postrst ptr", 32'(dut.ptr_q), 32'h1);
    x_valid = 4'b0000;

    // N=3: SEL=3 is out of range and must never grant.
    x3_valid = 3'b111;
    mode3    = 1'b1;
    sel3     = 2'd3;
    #1;
    chk("n3 sel3 x_ready", 32'(x3_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("n3 sel3 f_valid", 32'(f3_valid), 32'h0);
    mode3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ech;
      ech = 2'(k % 3);
      #1;
      chk($sformatf("n3 rr%0d x_ready", k), 32'(x3_ready), 32'(3'b001 << ech));
      @(posedge clk);
      #1;
      chk($sformatf("n3 rr%0d f_ch", k), 32'(f3_ch), 32'(ech));
      chk($sformatf("n3 rr%0d f_data", k), 32'(f3_data), 32'(8'hB0 + 8'(ech)));
    end
    x3_valid = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
